// File: rtl/ddr_ctrl_arbit.sv
// SDRAM bus arbiter: holds the pins in INIT, then grants refresh/write/read engines
// and muxes their command buses onto the pins, with a per-transaction watchdog.
module ddr_ctrl_arbit #(
  parameter logic [9:0] TXN_TIMEOUT = 10'd1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end_i,
  input  logic [3:0]  init_cmd_i,
  input  logic [1:0]  init_ba_i,
  input  logic [12:0] init_addr_i,
  input  logic        aref_req_i,
  input  logic        aref_end_i,
  input  logic [3:0]  aref_cmd_i,
  input  logic [1:0]  aref_ba_i,
  input  logic [12:0] aref_addr_i,
  input  logic        wr_req_i,
  input  logic        wr_end_i,
  input  logic [3:0]  wr_cmd_i,
  input  logic [1:0]  wr_ba_i,
  input  logic [12:0] wr_addr_i,
  input  logic        wr_sdram_en_i,
  input  logic [15:0] wr_sdram_data_i,
  input  logic        rd_req_i,
  input  logic        rd_end_i,
  input  logic [3:0]  rd_cmd_i,
  input  logic [1:0]  rd_ba_i,
  input  logic [12:0] rd_addr_i,
  input  logic [15:0] sdram_dq_i,
  output logic        aref_en_o,
  output logic        wr_en_o,
  output logic        rd_en_o,
  output logic [15:0] rd_data_o,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  output logic        err_timeout_o
);

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned BA_W   = 2;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DQ_W   = 16;
  localparam int unsigned CNT_W  = 10;

  localparam logic [CMD_W-1:0]  CMD_NOP   = 4'b0111;
  localparam logic [BA_W-1:0]   BA_IDLE   = 2'b11;
  localparam logic [ADDR_W-1:0] ADDR_IDLE = 13'h1fff;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               last_wr_q, last_wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               busy_c, end_c, expire_c;
  logic [CMD_W-1:0]   cmd_c;
  logic [BA_W-1:0]    ba_c;
  logic [ADDR_W-1:0]  addr_c;

  // End pulse of the granted engine only; other engines' pulses are ignored.
  always_comb begin
    busy_c = 1'b0;
    end_c  = 1'b0;
    unique case (state_q)
      ST_AREF:  begin busy_c = 1'b1; end_c = aref_end_i; end
      ST_WRITE: begin busy_c = 1'b1; end_c = wr_end_i;   end
      ST_READ:  begin busy_c = 1'b1; end_c = rd_end_i;   end
      default:  ;
    endcase
  end

  assign expire_c = (TXN_TIMEOUT != 10'd0) && busy_c && !end_c &&
                    (cnt_q == (TXN_TIMEOUT - 10'd1));

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_INIT;
    else            state_q <= state_d;
  end

  // Next state: refresh first, then write/read alternate via last_wr_q
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      ST_INIT: if (init_end_i) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req_i) begin
          state_d = ST_AREF;
        end else if (wr_req_i && (!rd_req_i || !last_wr_q)) begin
          state_d   = ST_WRITE;
          last_wr_d = 1'b1;
        end else if (rd_req_i) begin
          state_d   = ST_READ;
          last_wr_d = 1'b0;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: if (end_c || expire_c) state_d = ST_ARBIT;
      default: state_d = ST_INIT;
    endcase
  end

  // Watchdog counter and sticky error
  always_comb begin
    cnt_d = busy_c ? (cnt_q + 10'd1) : '0;
    err_d = err_q | expire_c;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_wr_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Output decode: grants and pin mux follow the current state directly
  always_comb begin
    aref_en_o = 1'b0;
    wr_en_o   = 1'b0;
    rd_en_o   = 1'b0;
    cmd_c     = CMD_NOP;
    ba_c      = BA_IDLE;
    addr_c    = ADDR_IDLE;
    unique case (state_q)
      ST_INIT: begin
        cmd_c = init_cmd_i; ba_c = init_ba_i; addr_c = init_addr_i;
      end
      ST_AREF: begin
        aref_en_o = 1'b1;
        cmd_c = aref_cmd_i; ba_c = aref_ba_i; addr_c = aref_addr_i;
      end
      ST_WRITE: begin
        wr_en_o = 1'b1;
        cmd_c = wr_cmd_i; ba_c = wr_ba_i; addr_c = wr_addr_i;
      end
      ST_READ: begin
        rd_en_o = 1'b1;
        cmd_c = rd_cmd_i; ba_c = rd_ba_i; addr_c = rd_addr_i;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_c;
  assign sdram_ba      = ba_c;
  assign sdram_addr    = addr_c;
  assign sdram_cke     = 1'b1;
  assign sdram_dq_oe   = (state_q == ST_WRITE) && wr_sdram_en_i;
  assign sdram_dq_o    = sdram_dq_oe ? wr_sdram_data_i : DQ_W'(0);
  assign rd_data_o     = sdram_dq_i;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_ddr_ctrl_arbit.sv
// Scoreboard bench for ddr_ctrl_arbit: a bus-ownership model predicts all pins every
// cycle; a separate monitor pops the prediction and compares against the DUT.
module tb_ddr_ctrl_arbit;

  localparam logic [9:0] TO = 10'd16;
  localparam int M_INIT = 0, M_IDLE = 1, M_AREF = 2, M_WR = 3, M_RD = 4;

  logic        sys_clk, sys_rst_n, init_end_i;
  logic [3:0]  init_cmd_i, aref_cmd_i, wr_cmd_i, rd_cmd_i;
  logic [1:0]  init_ba_i, aref_ba_i, wr_ba_i, rd_ba_i;
  logic [12:0] init_addr_i, aref_addr_i, wr_addr_i, rd_addr_i;
  logic        aref_req_i, aref_end_i, wr_req_i, wr_end_i, rd_req_i, rd_end_i;
  logic        wr_sdram_en_i;
  logic [15:0] wr_sdram_data_i, sdram_dq_i;
  logic        aref_en_o, wr_en_o, rd_en_o;
  logic [15:0] rd_data_o, sdram_dq_o;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic        sdram_dq_oe, err_timeout_o;

  int checks = 0;
  int errors = 0;
  bit dir_data = 1'b0;

  logic [56:0] exp_q[$];

  int m_own     = M_INIT;
  bit m_last_wr = 1'b0;
  int m_held    = 0;
  bit m_err     = 1'b0;

  ddr_ctrl_arbit #(.TXN_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end_i(init_end_i),
    .init_cmd_i(init_cmd_i), .init_ba_i(init_ba_i), .init_addr_i(init_addr_i),
    .aref_req_i(aref_req_i), .aref_end_i(aref_end_i),
    .aref_cmd_i(aref_cmd_i), .aref_ba_i(aref_ba_i), .aref_addr_i(aref_addr_i),
    .wr_req_i(wr_req_i), .wr_end_i(wr_end_i),
    .wr_cmd_i(wr_cmd_i), .wr_ba_i(wr_ba_i), .wr_addr_i(wr_addr_i),
    .wr_sdram_en_i(wr_sdram_en_i), .wr_sdram_data_i(wr_sdram_data_i),
    .rd_req_i(rd_req_i), .rd_end_i(rd_end_i),
    .rd_cmd_i(rd_cmd_i), .rd_ba_i(rd_ba_i), .rd_addr_i(rd_addr_i),
    .sdram_dq_i(sdram_dq_i),
    .aref_en_o(aref_en_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .rd_data_o(rd_data_o), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
    .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
    .err_timeout_o(err_timeout_o)
  );

  initial begin
    sys_clk = 1'b0;
    forever #3 sys_clk = ~sys_clk;
  end

  // Command buses and data change every cycle so the mux is exercised with fresh values.
  task automatic rand_buses();
    init_cmd_i = 4'($urandom);  init_ba_i = 2'($urandom);  init_addr_i = 13'($urandom);
    aref_cmd_i = 4'($urandom);  aref_ba_i = 2'($urandom);  aref_addr_i = 13'($urandom);
    wr_cmd_i   = 4'($urandom);  wr_ba_i   = 2'($urandom);  wr_addr_i   = 13'($urandom);
    rd_cmd_i   = 4'($urandom);  rd_ba_i   = 2'($urandom);  rd_addr_i   = 13'($urandom);
    wr_sdram_data_i = dir_data ? 16'hA5A5 : 16'($urandom);
    sdram_dq_i = 16'($urandom);
  endtask

  initial begin
    rand_buses();
    forever begin
      @(posedge sys_clk);
      #1;
      rand_buses();
    end
  end

  function automatic bit own_end(input int own);
    case (own)
      M_AREF:  return aref_end_i;
      M_WR:    return wr_end_i;
      M_RD:    return rd_end_i;
      default: return 1'b0;
    endcase
  endfunction

  // Ownership model: who holds the bus, how long, and who went last among W/R.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_own <= M_INIT; m_last_wr <= 1'b0; m_held <= 0; m_err <= 1'b0;
    end else begin
      case (m_own)
        M_INIT: if (init_end_i) m_own <= M_IDLE;
        M_IDLE: begin
          m_held <= 0;
          if (aref_req_i) m_own <= M_AREF;
          else if (wr_req_i && rd_req_i) begin
            m_own     <= m_last_wr ? M_RD : M_WR;
            m_last_wr <= !m_last_wr;
          end else if (wr_req_i) begin m_own <= M_WR; m_last_wr <= 1'b1; end
          else if (rd_req_i) begin m_own <= M_RD; m_last_wr <= 1'b0; end
        end
        default: begin
          if (own_end(m_own)) m_own <= M_IDLE;
          else if (m_held == int'(TO) - 1) begin m_own <= M_IDLE; m_err <= 1'b1; end
          else m_held <= m_held + 1;
        end
      endcase
    end
  end

  function automatic logic [56:0] build_exp(input int own, input bit err);
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    logic        oe;
    logic [15:0] d;
    case (own)
      M_INIT:  begin c = init_cmd_i; b = init_ba_i; a = init_addr_i; end
      M_AREF:  begin c = aref_cmd_i; b = aref_ba_i; a = aref_addr_i; end
      M_WR:    begin c = wr_cmd_i;   b = wr_ba_i;   a = wr_addr_i;   end
      M_RD:    begin c = rd_cmd_i;   b = rd_ba_i;   a = rd_addr_i;   end
      default: begin c = 4'b0111;    b = 2'b11;     a = 13'h1fff;    end
    endcase
    oe = (own == M_WR) && wr_sdram_en_i;
    d  = oe ? wr_sdram_data_i : 16'h0;
    return {1'b1, c, b, a, d, oe, sdram_dq_i,
            own == M_AREF, own == M_WR, own == M_RD, err};
  endfunction

  always @(negedge sys_clk) exp_q.push_back(build_exp(m_own, m_err));

  // Monitor: pops one prediction per cycle and compares all pins.
  initial begin
    logic [56:0] e, act;
    forever begin
      @(negedge sys_clk);
      #1;
      act = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
             sdram_ba, sdram_addr, sdram_dq_o, sdram_dq_oe, rd_data_o,
             aref_en_o, wr_en_o, rd_en_o, err_timeout_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t act=%h", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL pins t=%0t act=%h exp=%h", $time, act, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  function automatic bit dut_en(input int which);
    case (which)
      M_AREF:  return aref_en_o;
      M_WR:    return wr_en_o;
      default: return rd_en_o;
    endcase
  endfunction

  task automatic wait_grant(input int which);
    bit got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (dut_en(which)) got = 1'b1;
      else tick(1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout engine=%0d act=0 exp=1", which);
    end
  endtask

  task automatic wait_any(output int which);
    which = M_IDLE;
    for (int k = 0; k < 300 && which == M_IDLE; k++) begin
      if (aref_en_o) which = M_AREF;
      else if (wr_en_o) which = M_WR;
      else if (rd_en_o) which = M_RD;
      else tick(1);
    end
    checks++;
    if (which == M_IDLE) begin
      errors++;
      $display("FAIL any_grant_timeout act=none exp=grant");
    end
  endtask

  task automatic pulse_end(input int which, input int hold, input bit drop);
    wait_grant(which);
    tick(hold);
    case (which)
      M_AREF:  begin aref_end_i = 1'b1; if (drop) aref_req_i = 1'b0; end
      M_WR:    begin wr_end_i   = 1'b1; if (drop) wr_req_i   = 1'b0; end
      default: begin rd_end_i   = 1'b1; if (drop) rd_req_i   = 1'b0; end
    endcase
    tick(1);
    aref_end_i = 1'b0; wr_end_i = 1'b0; rd_end_i = 1'b0;
  endtask

  initial begin
    int w;
    sys_rst_n = 1'b0; init_end_i = 1'b0;
    aref_req_i = 1'b0; aref_end_i = 1'b0;
    wr_req_i = 1'b0; wr_end_i = 1'b0; rd_req_i = 1'b0; rd_end_i = 1'b0;
    wr_sdram_en_i = 1'b0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(20);
    init_end_i = 1'b1;
    tick(3);

    // All three request together: AREF, then WRITE, then READ despite wr_req held
    aref_req_i = 1'b1; wr_req_i = 1'b1; rd_req_i = 1'b1;
    pulse_end(M_AREF, 3, 1'b1);
    pulse_end(M_WR, 4, 1'b0);
    pulse_end(M_RD, 4, 1'b0);
    repeat (6) begin
      wait_any(w);
      pulse_end(w, 8, 1'b0);
    end
    wait_any(w);
    wr_req_i = 1'b0; rd_req_i = 1'b0;
    pulse_end(w, 2, 1'b0);
    tick(3);

    // Refresh arriving during a read waits for rd_end_i
    rd_req_i = 1'b1;
    wait_grant(M_RD);
    tick(3);
    aref_req_i = 1'b1;
    tick(3);
    rd_end_i = 1'b1; rd_req_i = 1'b0;
    tick(1);
    rd_end_i = 1'b0;
    pulse_end(M_AREF, 2, 1'b1);
    tick(2);

    // DQ drive only while writing
    dir_data = 1'b1; wr_sdram_en_i = 1'b1;
    tick(1);
    wr_req_i = 1'b1;
    pulse_end(M_WR, 4, 1'b1);
    rd_req_i = 1'b1;
    pulse_end(M_RD, 4, 1'b1);
    dir_data = 1'b0; wr_sdram_en_i = 1'b0;
    tick(2);

    // Watchdog: read never ends
    rd_req_i = 1'b1;
    wait_grant(M_RD);
    rd_req_i = 1'b0;
    tick(25);
    aref_req_i = 1'b1;
    pulse_end(M_AREF, 2, 1'b1);
    tick(3);

    // Random traffic, including end pulses from non-granted engines
    for (int i = 0; i < 3000; i++) begin
      aref_req_i    = ($urandom_range(0, 9) == 0);
      wr_req_i      = ($urandom_range(0, 2) != 0);
      rd_req_i      = ($urandom_range(0, 2) != 0);
      aref_end_i    = ($urandom_range(0, 4) == 0);
      wr_end_i      = ($urandom_range(0, 4) == 0);
      rd_end_i      = ($urandom_range(0, 4) == 0);
      wr_sdram_en_i = 1'($urandom);
      tick(1);
    end
    aref_req_i = 1'b0; wr_req_i = 1'b0; rd_req_i = 1'b0;
    aref_end_i = 1'b0; wr_end_i = 1'b0; rd_end_i = 1'b0;
    tick(20);

    // Reset in the middle of a write
    wr_req_i = 1'b1; wr_sdram_en_i = 1'b1;
    wait_grant(M_WR);
    tick(2);
    sys_rst_n = 1'b0;
    tick(2);
    wr_req_i = 1'b0; wr_sdram_en_i = 1'b0;
    sys_rst_n = 1'b1;
    tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_ctrl_arbit.md
Name: ddr_ctrl_arbit

Overview:
- Central arbiter and command multiplexer of the SDRAM controller.
- Holds the bus in INIT until the init module finishes. It then grants the SDRAM command/address/DQ bus to one of three engines: auto-refresh, write or read.
- Priority order: refresh first, then write and read round-robin.
- Drives the SDRAM pins. Includes a per-transaction watchdog that recovers the bus if an engine never signals end.

Parameters:
- TXN_TIMEOUT, 1023: max cycles a granted engine may hold the bus before forced release. Width 10 bits; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock, 166.66MHz
- sys_rst_n  in  1  asynchronous reset, active low
- init_end_i  in  1  init sequence complete (level, stays high)
- init_cmd_i/init_ba_i/init_addr_i  in  4/2/13  init command {cs_n,ras_n,cas_n,we_n}, bank, address
- aref_req_i  in  1  refresh request (level, held until serviced)
- aref_end_i  in  1  refresh done pulse
- aref_cmd_i/aref_ba_i/aref_addr_i  in  4/2/13  refresh command bus
- wr_req_i  in  1  write request (level)
- wr_end_i  in  1  write burst done pulse
- wr_cmd_i/wr_ba_i/wr_addr_i  in  4/2/13  write command bus
- wr_sdram_en_i  in  1  write engine drives DQ
- wr_sdram_data_i  in  16  write data
- rd_req_i  in  1  read request (level)
- rd_end_i  in  1  read burst done pulse
- rd_cmd_i/rd_ba_i/rd_addr_i  in  4/2/13  read command bus
- sdram_dq_i  in  16  DQ input from pad
- aref_en_o/wr_en_o/rd_en_o  out  1  grant enables to the engines
- rd_data_o  out  16  sdram_dq_i passed through to the read engine
- sdram_cke  out  1  clock enable
- sdram_cs_n/sdram_ras_n/sdram_cas_n/sdram_we_n  out  1  command pins
- sdram_ba  out  2  bank
- sdram_addr  out  13  address
- sdram_dq_o  out  16  DQ output
- sdram_dq_oe  out  1  DQ output enable
- err_timeout_o  out  1  sticky watchdog error flag

Behaviour:
- States: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT. The state register and err_timeout_o are asynchronously reset; err_timeout_o resets to 0.
- INIT -> ARBIT when init_end_i=1.
- ARBIT decision, one cycle:
  - aref_req_i=1 -> AREF.
  - Else wr_req_i and rd_req_i both 1 -> the engine not equal to last_grant (1-bit reg, reset = READ, so write wins first).
  - Else wr_req_i=1 -> WRITE.
  - Else rd_req_i=1 -> READ.
  - Else stay in ARBIT.
- last_grant is updated on entry to WRITE or READ only; AREF does not change it.
- AREF/WRITE/READ -> ARBIT on the respective end pulse, or on watchdog expiry.
- A request raised while another engine is granted waits. A refresh arriving mid-burst never preempts.
- Enables are combinational: aref_en_o=(state==AREF), wr_en_o=(state==WRITE), rd_en_o=(state==READ). All are 0 at reset. An enable drops in the same edge as the end pulse, so the engine returning to idle sees en=0.
- Command mux is combinational from state:
  - INIT -> init_* buses; AREF -> aref_*; WRITE -> wr_*; READ -> rd_*.
  - ARBIT -> NOP (4'b0111), ba 2'b11, addr 13'h1fff.
  - At reset the pins therefore follow init_* inputs.
- sdram_cke = 1 constantly, including during reset.
- sdram_dq_oe = (state==WRITE) && wr_sdram_en_i. sdram_dq_o = wr_sdram_data_i when sdram_dq_oe=1, else 16'h0.
- rd_data_o = sdram_dq_i unconditionally.
- Watchdog:
  - 10-bit cnt_txn is cleared in INIT and ARBIT and increments in AREF/WRITE/READ.
  - If TXN_TIMEOUT!=0 and cnt_txn==TXN_TIMEOUT-1 with no end pulse: state -> ARBIT next edge and err_timeout_o set to 1 (sticky until reset).
  - If the end pulse and expiry coincide, the end pulse wins and no error is flagged.
- End pulses from non-granted engines are ignored.
- Reset mid-transaction: immediate INIT and all enables 0. last_grant and cnt_txn are also cleared.

Test Plan:
- Reset, init_end_i=0 for 20 cycles, then 1 -> pins follow init_* for 20 cycles. ARBIT in cycle 21 drives NOP/ba=3/addr=1fff; all enables 0.
- After init, aref_req_i, wr_req_i and rd_req_i all 1 together -> AREF granted first. After aref_end_i, WRITE is granted. After wr_end_i, READ is granted, even with wr_req_i still 1.
- wr_req_i and rd_req_i held high continuously with ends every 8 cycles -> grants alternate W,R,W,R; no double grant.
- aref_req_i rises in the middle of a READ -> READ continues until rd_end_i, then AREF is next. rd_en_o low in the cycle after rd_end_i.
- WRITE with wr_sdram_en_i=1 and data 16'hA5A5 -> sdram_dq_oe=1 and sdram_dq_o=16'hA5A5. The same stimulus during READ gives oe=0 and dq_o=0.
- TXN_TIMEOUT=16, grant READ and never pulse rd_end_i -> state returns to ARBIT after 16 cycles. err_timeout_o=1 and stays 1 until sys_rst_n falls.
